// File: rtl/hwpe_stream_split_stride_buf_if.sv
// HWPE-Stream handshake bundle: valid/ready with data and byte strobes.
// Producers use source (alias master); consumers use sink (alias slave).
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_split_stride_buf.sv
// Buffered stream splitter: one wide input beat fanned out to NB_OUT_STREAMS outputs (stride or block mapping, eager fork).
// Optional macro HWPE_STREAM_SPLIT_STRIDE_SKIP_EMPTY_EN suppresses outputs whose mapped strobe is all zero.
module hwpe_stream_split_stride_buf #(
  parameter int unsigned NB_OUT_STREAMS = 4,
  parameter int unsigned DATA_WIDTH_IN  = 256,
  parameter int unsigned ELEMENT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   mode_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o [NB_OUT_STREAMS],
  output logic                   empty_o,
  output logic                   full_o,
  output logic [CNT_WIDTH-1:0]   beat_cnt_o
);
  localparam int unsigned EPO            = DATA_WIDTH_IN / (NB_OUT_STREAMS * ELEMENT_WIDTH);
  localparam int unsigned DATA_WIDTH_OUT = EPO * ELEMENT_WIDTH;
  localparam int unsigned BPE            = ELEMENT_WIDTH / 8;
  localparam int unsigned STRB_IN        = DATA_WIDTH_IN / 8;
  localparam int unsigned STRB_OUT       = DATA_WIDTH_OUT / 8;
  localparam int unsigned PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W          = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH_IN-1:0] data_mem [FIFO_DEPTH];
  logic [STRB_IN-1:0]       strb_mem [FIFO_DEPTH];
  logic                     mode_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]          occ_reg, occ_next;
  logic                      full_reg, empty_reg;
  logic [NB_OUT_STREAMS-1:0] done_reg;
  logic [CNT_WIDTH-1:0]      cnt_reg;

  logic [DATA_WIDTH_IN-1:0] head_data;
  logic [STRB_IN-1:0]       head_strb;
  logic                     head_mode;

  logic [NB_OUT_STREAMS-1:0][DATA_WIDTH_OUT-1:0] out_data;
  logic [NB_OUT_STREAMS-1:0][STRB_OUT-1:0]       out_strb;
  logic [NB_OUT_STREAMS-1:0]                     out_valid, out_ready, hs, skip;

  logic accept, retire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = data_mem[rd_ptr_reg];
  assign head_strb = strb_mem[rd_ptr_reg];
  assign head_mode = mode_mem[rd_ptr_reg];

  // Ready depends only on the registered full flag, never on downstream readies.
  assign push_i.ready = ~full_reg;
  assign accept       = push_i.valid & ~full_reg;
  assign retire       = ~empty_reg & (&(done_reg | skip | hs));

  genvar gi, gj;
  generate
    for (gi = 0; gi < NB_OUT_STREAMS; gi++) begin : g_out
      for (gj = 0; gj < EPO; gj++) begin : g_lane
        localparam int unsigned STRIDE_IDX = gi + gj * NB_OUT_STREAMS;
        localparam int unsigned BLOCK_IDX  = gi * EPO + gj;
        assign out_data[gi][gj*ELEMENT_WIDTH +: ELEMENT_WIDTH] = head_mode
          ? head_data[BLOCK_IDX*ELEMENT_WIDTH +: ELEMENT_WIDTH]
          : head_data[STRIDE_IDX*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        assign out_strb[gi][gj*BPE +: BPE] = head_mode
          ? head_strb[BLOCK_IDX*BPE +: BPE]
          : head_strb[STRIDE_IDX*BPE +: BPE];
      end

`ifdef HWPE_STREAM_SPLIT_STRIDE_SKIP_EMPTY_EN
      assign skip[gi] = ~|out_strb[gi];
`else
      assign skip[gi] = 1'b0;
`endif

      assign out_valid[gi]   = ~empty_reg & ~done_reg[gi] & ~skip[gi];
      assign out_ready[gi]   = pop_o[gi].ready;
      assign hs[gi]          = out_valid[gi] & out_ready[gi];
      assign pop_o[gi].valid = out_valid[gi];
      assign pop_o[gi].data  = out_data[gi];
      assign pop_o[gi].strb  = out_strb[gi];
    end
  endgenerate

  always_comb begin
    occ_next = occ_reg;
    if (accept && !retire) begin
      occ_next = occ_reg + 1'b1;
    end else if (!accept && retire) begin
      occ_next = occ_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_mem[wr_ptr_reg] <= push_i.data;
      strb_mem[wr_ptr_reg] <= push_i.strb;
      mode_mem[wr_ptr_reg] <= mode_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      done_reg   <= '0;
      cnt_reg    <= '0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (retire) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        done_reg   <= '0;
        cnt_reg    <= cnt_reg + 1'b1;
      end else begin
        done_reg <= done_reg | hs;
      end
      occ_reg   <= occ_next;
      full_reg  <= (occ_next == OCC_W'(FIFO_DEPTH));
      empty_reg <= (occ_next == '0);
    end
  end

  assign empty_o    = empty_reg;
  assign full_o     = full_reg;
  assign beat_cnt_o = cnt_reg;
endmodule

// File: doc/hwpe_stream_split_stride_buf.md
Name: hwpe_stream_split_stride_buf

Overview:
- Buffered successor to the strided stream splitter. Accepts DATA_WIDTH_IN-bit beats on one HWPE-Stream sink and distributes the elements to NB_OUT_STREAMS output streams.
- Two element-mapping modes, selected per beat: stride (interleaved) and block (contiguous).
- Each output completes its handshake independently (eager fork). A FIFO_DEPTH-entry input buffer decouples the producer from output stalls.
- Sits between HWPE datapath and TCDM store streamers.

Parameters:
- NB_OUT_STREAMS, 4, number of output streams.
- DATA_WIDTH_IN, 256, input data width in bits.
- ELEMENT_WIDTH, 16, element width in bits. Must be a multiple of 8.
- FIFO_DEPTH, 2, number of buffered input beats. Must be at least 1.
- CNT_WIDTH, 16, width of the retired-beat counter.
- Derived:
  - EPO = DATA_WIDTH_IN/(NB_OUT_STREAMS*ELEMENT_WIDTH), elements per output. Must be an integer of at least 1.
  - DATA_WIDTH_OUT = EPO*ELEMENT_WIDTH.
  - BPE = ELEMENT_WIDTH/8, bytes per element.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- mode_i  in  1  0 = stride, 1 = block. Sampled together with the push handshake.
- push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH_IN  input stream.
- pop_o[NB_OUT_STREAMS-1:0]  hwpe_stream_intf_stream.source  DATA_WIDTH_OUT  output streams.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- beat_cnt_o  out  CNT_WIDTH  count of retired beats; wraps modulo 2^CNT_WIDTH.

Behaviour:
- FIFO entry contents: data, strb, mode bit.
  - push_i.ready = !full_o. Registered; no combinational path from any pop_o.ready.
  - Accept: push_i.valid && push_i.ready writes the tail entry.
  - Full FIFO: no push is accepted, even in a cycle where the head retires.
- Latency: a beat accepted in cycle N is visible on the outputs in cycle N+1 at the earliest.
- Head presentation: done[NB_OUT_STREAMS-1:0] register.
  - pop_o[i].valid = !empty_o && !done[i].
  - Once asserted, valid holds, with data and strb stable, until pop_o[i].ready.
- Retire condition: for every i, done[i] || (pop_o[i].valid && pop_o[i].ready).
  - On retire: advance the head, clear done, increment beat_cnt_o.
  - Otherwise each completed handshake sets its done[i].
- Simultaneous accept and retire in the same cycle: occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Mapping, for output i and lane j (j = 0..EPO-1). Lane j occupies pop_o[i].data bits [(j+1)*ELEMENT_WIDTH-1 : j*ELEMENT_WIDTH].
  - Stride mode: lane j = input element i + j*NB_OUT_STREAMS.
  - Block mode: lane j = input element i*EPO + j.
- Strobe follows data: the BPE strobe bits of the selected element move with it, in byte order.
- Reset or clear, including mid-beat:
  - FIFO emptied, done cleared, beat_cnt_o = 0.
  - All pop_o valid = 0; push_i.ready = 1 on the next cycle.
  - Partially delivered beats are dropped.
- Reset values: empty_o = 1, full_o = 0, beat_cnt_o = 0, every pop_o.valid = 0.

Optional Feature:
- Macro: HWPE_STREAM_SPLIT_STRIDE_SKIP_EMPTY_EN.
- Defined:
  - An output whose mapped strobe is all zero for the head beat never asserts valid. It is treated as done from the first cycle of presentation.
  - A beat with all-zero strobe retires one cycle after it reaches the head.
  - beat_cnt_o still counts such beats.
- Undefined: every output asserts valid for every beat, regardless of strobe.

Test Plan:
- Stride mapping: default params, mode_i = 0, element k = k, all outputs ready. Required response:
  - pop_o[0] lanes = 0, 4, 8, 12.
  - pop_o[3] lanes = 3, 7, 11, 15.
  - Output valid one cycle after accept; beat_cnt_o = 1 after the beat retires.
- Block mapping with strobe: mode_i = 1, element k = k, strb all ones except bytes 10 and 11 (element 5). Required response:
  - pop_o[1] lanes = 4, 5, 6, 7.
  - pop_o[1].strb = 8'b1111_0011; all other outputs strb = 8'hFF.
- Eager fork: pop_o[2].ready held 0 for 5 cycles, all others 1. Required response:
  - Outputs 0, 1 and 3 drop valid after one cycle; pop_o[2] holds valid and data.
  - Beat retires in the cycle pop_o[2].ready rises.
- Backpressure and full: all outputs not ready, push 3 beats. Required response:
  - 2 beats accepted, full_o = 1, push_i.ready = 0.
  - Release all readies: beats emerge in order on consecutive cycles; beat_cnt_o = 2.
  - Third beat is then accepted.
- Clear mid-beat: assert clear_i while outputs 0 and 1 are done. Required response:
  - Next cycle: all valid = 0, empty_o = 1, beat_cnt_o = 0.
  - Next pushed beat is delivered to all 4 outputs.
- Skip-empty, macro defined: beat with strb nonzero only in element 0, stride mode. Required response:
  - Only pop_o[0] asserts valid; beat retires on its handshake.
  - With the macro undefined, all 4 outputs assert valid.
